// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic [31:0] OOR_DATA = 32'hdead_beef;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] limit);
    return addr > limit;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker: round-robin against the last grant, or port 1 priority.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       fixed_prio_i,
  output logic       gnt_id_o,
  output logic       gnt_valid_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = PORT_IF;
    if (req_i == 2'b11) begin
      // On a tie the port not served last wins unless port 1 has fixed priority.
      gnt_id_o = fixed_prio_i ? PORT_LSU : ~last_grant_i;
    end else if (req_i[1]) begin
      gnt_id_o = PORT_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory between instruction fetch (port 0) and the LSU (port 1);
// every output is registered from the next-state decode.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter logic [31:0] ADDR_LIMIT = 32'd16383
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [3:0]  p0_be_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [3:0]  p1_be_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p0_ready_o,
  output logic [31:0] p0_rdata_o,
  output logic        p0_err_o,
  output logic        p1_ready_o,
  output logic [31:0] p1_rdata_o,
  output logic        p1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  arb_state_t  state_q, state_d;
  mem_req_t    lat_q, lat_d;
  logic        port_q, port_d;
  logic        last_q, last_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        p0_ready_q, p0_ready_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic        p0_err_q, p0_err_d;
  logic        p1_ready_q, p1_ready_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p1_err_q, p1_err_d;

  logic        rsp_load;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        gnt_id;
  logic        gnt_valid;

  rr_arb2 u_rr_arb2 (
    .req_i        ({p1_req_i, p0_req_i}),
    .last_grant_i (last_q),
    .fixed_prio_i (FIXED_PRIO != 0),
    .gnt_id_o     (gnt_id),
    .gnt_valid_o  (gnt_valid)
  );

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    port_d   = port_q;
    last_d   = last_q;
    rsp_load = 1'b0;
    rsp_data = '0;
    rsp_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          port_d = gnt_id;
          if (gnt_id == PORT_LSU) begin
            lat_d.we    = p1_we_i;
            lat_d.be    = p1_be_i;
            lat_d.addr  = p1_addr_i;
            lat_d.wdata = p1_wdata_i;
          end else begin
            lat_d.we    = p0_we_i;
            lat_d.be    = p0_be_i;
            lat_d.addr  = p0_addr_i;
            lat_d.wdata = p0_wdata_i;
          end
          // Out-of-range requests complete straight away without a memory cycle.
          if (addr_oor(lat_d.addr, ADDR_LIMIT)) begin
            state_d  = RESP;
            rsp_load = 1'b1;
            rsp_data = OOR_DATA;
            rsp_err  = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (mem_ready_i) begin
          if (lat_q.we) begin
            state_d  = RESP;
            rsp_load = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (mem_ready_i) begin
          state_d  = RESP;
          rsp_load = 1'b1;
          rsp_data = mem_rdata_i;
        end
      end
      RESP: begin
        last_d  = port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The memory request is held through DATA so the registered read stays valid.
    mem_req_d   = (state_d == ADDR) || (state_d == DATA);
    mem_we_d    = (state_d == ADDR) && lat_d.we;
    mem_be_d    = mem_req_d ? lat_d.be    : 4'b0000;
    mem_addr_d  = mem_req_d ? lat_d.addr  : 32'd0;
    mem_wdata_d = mem_req_d ? lat_d.wdata : 32'd0;

    p0_ready_d = rsp_load && (port_d == PORT_IF);
    p1_ready_d = rsp_load && (port_d == PORT_LSU);
    p0_rdata_d = p0_ready_d ? rsp_data : p0_rdata_q;
    p0_err_d   = p0_ready_d ? rsp_err  : p0_err_q;
    p1_rdata_d = p1_ready_d ? rsp_data : p1_rdata_q;
    p1_err_d   = p1_ready_d ? rsp_err  : p1_err_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      port_q      <= PORT_IF;
      last_q      <= PORT_LSU;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      p0_ready_q  <= 1'b0;
      p0_rdata_q  <= 32'd0;
      p0_err_q    <= 1'b0;
      p1_ready_q  <= 1'b0;
      p1_rdata_q  <= 32'd0;
      p1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      port_q      <= port_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_ready_q  <= p0_ready_d;
      p0_rdata_q  <= p0_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_ready_q  <= p1_ready_d;
      p1_rdata_q  <= p1_rdata_d;
      p1_err_q    <= p1_err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign p0_ready_o  = p0_ready_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p0_err_o    = p0_err_q;
  assign p1_ready_o  = p1_ready_q;
  assign p1_rdata_o  = p1_rdata_q;
  assign p1_err_o    = p1_err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer that shares the single external data memory between instruction fetch (port 0) and load/store unit (port 1).
- Requesters hold their request stable until a one-cycle completion pulse.
- Drives the memory's req/we/be/addr/wdata interface and holds the request through the memory's one-cycle registered read, so read data is valid while req stays high.
- Captures the read word and returns it to the winning requester.
- Rejects out-of-range addresses without touching memory.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 1 always wins a simultaneous request.
- ADDR_LIMIT, 32'd16383, highest valid byte address; anything above is out of range.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-low reset (rst_i = 0 resets on clk_i edge)
- p0_req_i / p1_req_i  in  1  request; held with its fields until pN_ready_o
- p0_we_i / p1_we_i  in  1  1 = write, 0 = read
- p0_be_i / p1_be_i  in  4  byte enables (writes only)
- p0_addr_i / p1_addr_i  in  32  byte address
- p0_wdata_i / p1_wdata_i  in  32  write data
- p0_ready_o / p1_ready_o  out  1  one-cycle completion pulse
- p0_rdata_o / p1_rdata_o  out  32  read data, valid with ready pulse
- p0_err_o / p1_err_o  out  1  out-of-range flag, valid with ready pulse
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enable
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, combinational, valid in cycle after address while req held
- mem_ready_i  in  1  memory ready

Behaviour:
- Reset (rst_i = 0 at edge): state IDLE; all outputs 0; latched request fields 0; rr pointer set so port 0 wins first tie.
- FSM states: IDLE, ADDR, DATA, RESP.
- All mem_* outputs and pN_* outputs are registered.
- IDLE:
  - mem_req_o = 0.
  - If any req: pick winner (rr_arb2), latch its we/be/addr/wdata and port id.
  - If addr > ADDR_LIMIT: go RESP with err = 1, rdata = 32'hdead_beef, no memory access.
  - Otherwise go ADDR.
- ADDR:
  - mem_req_o = 1; mem_we/be/addr/wdata from latched fields.
  - If mem_ready_i = 0: stay.
  - Write: go RESP.
  - Read: go DATA.
- DATA:
  - mem_req_o = 1, mem_we_o = 0, same addr.
  - If mem_ready_i = 1: capture mem_rdata_i into rdata_q and go RESP; else stay.
- RESP:
  - mem_req_o = 0.
  - Granted port's ready_o = 1 for exactly one cycle with rdata_q and err; other port's ready_o = 0.
  - Update rr pointer to the just-served port; go IDLE.
- Latency from req seen in IDLE: write ready 2 cycles later; read 3; out-of-range 1.
- Write completion returns rdata = 0, err = 0.
- Round-robin: on simultaneous requests, the port not served last wins. A single requester is always granted.
- FIXED_PRIO = 1: port 1 wins ties; the rr pointer is unused.
- A loser's request is ignored until the next IDLE; its inputs must remain stable.
- A requester dropping req while not granted is allowed. Dropping req after grant is illegal; the latched copy completes regardless.
- rdata/err outputs hold their value until the next RESP for that port.
- Back-to-back: a request present in the cycle after RESP (IDLE) is arbitrated immediately; no bubble beyond IDLE.
- Reset mid-transaction: abort at the edge; no ready pulse issued; mem_req_o = 0 next cycle.

Decomposition:
- Package mem_arb_pkg:
  - state enum arb_state_t {IDLE, ADDR, DATA, RESP}
  - localparam OOR_DATA = 32'hdead_beef
  - port id constants PORT_IF = 1'b0, PORT_LSU = 1'b1
  - request struct mem_req_t {we, be, addr, wdata}
- Sub-module rr_arb2: combinational two-way picker with inputs req[1:0], last_grant, fixed_prio; outputs gnt_id, gnt_valid.

Test Plan:
- p0 read addr 0x10 (memory word 0xCAFE0001), p1 idle -> mem_req_o high for 2 cycles with addr 0x10; p0_ready_o pulses 3 cycles after req, p0_rdata_o = 0xCAFE0001, err = 0.
- p1 write addr 0x20, be = 4'b0011, wdata = 0x12345678 over 0xAAAAAAAA, then p1 read 0x20 -> write ready after 2 cycles; read returns 0xAAAA5678.
- Both request continuously, FIXED_PRIO = 0 -> grants alternate p0, p1, p0, p1; each ready pulse is one cycle and never on both ports.
- Same stimulus, FIXED_PRIO = 1 -> p1 served every time, p0 starved until p1 drops req.
- p0 read addr 0x4000 -> no mem_req_o; p0_ready_o 1 cycle later with rdata = 0xdead_beef, err = 1.
- rst_i = 0 asserted in DATA -> next cycle all outputs 0, state IDLE, no ready pulse; after release, pending p1 request is served normally with port 0 still favoured for first tie.
